depth_reorder_buffer: RTL and testbench

Sits between a pool of NUM_ENGINES depth_calculator instances and the packer, in the out_stream_aclk domain. Walks pixels in raster order and issues each coordinate to an idle engine. Collects the out-of-order iteration depths into a tagged reorder buffer. Emits depths strictly in raster order on a valid/ready stream, with x, y, sof and eol, for the colour LUT and packer.

---
 rtl/depth_reorder_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_depth_reorder_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depth_reorder_buffer.sv
`timescale 1ns/1ps
// depth_reorder_buffer
// Hands raster-ordered pixel coordinates to a pool of depth engines and
// collects their results, which can come back in any order, in a tagged
// reorder buffer. Depths leave strictly in raster order on a valid/ready
// stream carrying x, y, sof and eol.
// Optional build macro: ROB_STATS_EN adds the stat_frames and stat_starve
// counters.
module depth_reorder_buffer #(
  parameter int X_SIZE      = 640,
  parameter int Y_SIZE      = 480,
  parameter int NUM_ENGINES = 4,
  parameter int ROB_DEPTH   = 8,
  parameter int DEPTH_W     = 10
) (
  input  logic                           out_stream_aclk,
  input  logic                           periph_resetn,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [9:0]                     issue_x,
  output logic [8:0]                     issue_y,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DEPTH_W-1:0]             out_depth,
  output logic [9:0]                     out_x,
  output logic [8:0]                     out_y,
  output logic                           out_sof,
  output logic                           out_eol
`ifdef ROB_STATS_EN
  ,
  output logic [15:0]                    stat_frames,
  output logic [31:0]                    stat_starve
`endif
);

  localparam int TAG_W  = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int CNT_W  = $clog2(ROB_DEPTH + 1);
  localparam int EIDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  // Per-engine state
  logic [NUM_ENGINES-1:0] busy_q;
  logic [TAG_W-1:0]       tag_q [NUM_ENGINES];
  // Per-slot state
  logic [ROB_DEPTH-1:0]   filled_q;
  logic [DEPTH_W-1:0]     depth_q [ROB_DEPTH];
  // Pointers, occupancy and raster counters
  logic [TAG_W-1:0]       tail_q, tail_d, head_q, head_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [9:0]             ix_q, ix_d, ox_q, ox_d;
  logic [8:0]             iy_q, iy_d, oy_q, oy_d;
  // Registered issue outputs
  logic [NUM_ENGINES-1:0] start_q;
  logic [9:0]             issue_x_q;
  logic [8:0]             issue_y_q;

  logic                   issue_found, issue_en, accept;
  logic [EIDX_W-1:0]      issue_idx;
  logic [NUM_ENGINES-1:0] issue_onehot;
  logic [NUM_ENGINES-1:0] done_acc;
  logic [DEPTH_W-1:0]     eng_slice [NUM_ENGINES];

  // Results from idle engines are stale (e.g. issued before a reset) and dropped
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENGINES; gi++) begin : g_eng
      assign eng_slice[gi] = eng_depth[gi*DEPTH_W +: DEPTH_W];
      assign done_acc[gi]  = eng_done[gi] & busy_q[gi];
    end
  endgenerate

  function automatic logic [TAG_W-1:0] inc_ptr(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(ROB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pick the lowest-index idle engine; issue only while a reorder slot is free
  always_comb begin
    issue_found  = 1'b0;
    issue_idx    = '0;
    issue_onehot = '0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        issue_found = 1'b1;
        issue_idx   = EIDX_W'(i);
      end
    end
    issue_en = issue_found && (count_q < CNT_W'(ROB_DEPTH));
    if (issue_en) issue_onehot[issue_idx] = 1'b1;
  end

  assign out_valid = filled_q[head_q];
  assign accept    = out_valid && out_ready;

  // Next-state for pointers, occupancy and both raster counters
  always_comb begin
    tail_d  = tail_q;
    head_d  = head_q;
    count_d = count_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    if (issue_en) begin
      tail_d = inc_ptr(tail_q);
      if (ix_q == 10'(X_SIZE - 1)) begin
        ix_d = '0;
        iy_d = (iy_q == 9'(Y_SIZE - 1)) ? '0 : iy_q + 1'b1;
      end else begin
        ix_d = ix_q + 1'b1;
      end
    end
    if (accept) begin
      head_d = inc_ptr(head_q);
      if (ox_q == 10'(X_SIZE - 1)) begin
        ox_d = '0;
        oy_d = (oy_q == 9'(Y_SIZE - 1)) ? '0 : oy_q + 1'b1;
      end else begin
        ox_d = ox_q + 1'b1;
      end
    end
    case ({issue_en, accept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer, counter and issue-output registers
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      tail_q    <= '0;
      head_q    <= '0;
      count_q   <= '0;
      ix_q      <= '0;
      iy_q      <= '0;
      ox_q      <= '0;
      oy_q      <= '0;
      start_q   <= '0;
      issue_x_q <= '0;
      issue_y_q <= '0;
    end else begin
      tail_q  <= tail_d;
      head_q  <= head_d;
      count_q <= count_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      start_q <= issue_onehot;
      if (issue_en) begin
        issue_x_q <= ix_q;
        issue_y_q <= iy_q;
      end
    end
  end

  // Engine busy/tag tracking: set on issue, cleared by an accepted done
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) tag_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (done_acc[i]) busy_q[i] <= 1'b0;
        if (issue_onehot[i]) begin
          busy_q[i] <= 1'b1;
          tag_q[i]  <= tail_q;
        end
      end
    end
  end

  // Slot storage: head slot freed on accept, done results land in their tagged slot
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      filled_q <= '0;
      for (int s = 0; s < ROB_DEPTH; s++) depth_q[s] <= '0;
    end else begin
      if (accept) filled_q[head_q] <= 1'b0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (done_acc[i]) begin
          filled_q[tag_q[i]] <= 1'b1;
          depth_q[tag_q[i]]  <= eng_slice[i];
        end
      end
    end
  end

  assign eng_start = start_q;
  assign issue_x   = issue_x_q;
  assign issue_y   = issue_y_q;
  assign out_depth = depth_q[head_q];
  assign out_x     = ox_q;
  assign out_y     = oy_q;
  assign out_sof   = (ox_q == 10'd0) && (oy_q == 9'd0);
  assign out_eol   = (ox_q == 10'(X_SIZE - 1));

`ifdef ROB_STATS_EN
  logic [15:0] stat_frames_q;
  logic [31:0] stat_starve_q;

  // Frame counter wraps; starve counter saturates
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      stat_frames_q <= '0;
      stat_starve_q <= '0;
    end else begin
      if (accept && out_eol && (oy_q == 9'(Y_SIZE - 1)))
        stat_frames_q <= stat_frames_q + 1'b1;
      if (out_ready && !out_valid && (stat_starve_q != '1))
        stat_starve_q <= stat_starve_q + 1'b1;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_starve = stat_starve_q;
`endif

endmodule

// File: tb/tb_depth_reorder_buffer.sv
`timescale 1ns/1ps
// Scoreboard bench for depth_reorder_buffer: a behavioural engine pool pushes
// the expected in-order result at every issue; a monitor pops and compares on
// every accepted output.
module tb_depth_reorder_buffer;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int NE = 4;
  localparam int RD = 8;
  localparam int DW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [NE-1:0]    eng_start;
  logic [9:0]       issue_x;
  logic [8:0]       issue_y;
  logic [NE-1:0]    eng_done = '0;
  logic [NE*DW-1:0] eng_depth = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    out_depth;
  logic [9:0]       out_x;
  logic [8:0]       out_y;
  logic             out_sof, out_eol;
`ifdef ROB_STATS_EN
  logic [15:0]      stat_frames;
  logic [31:0]      stat_starve;
`endif

  depth_reorder_buffer #(
    .X_SIZE(XS), .Y_SIZE(YS), .NUM_ENGINES(NE), .ROB_DEPTH(RD), .DEPTH_W(DW)
  ) dut (
    .out_stream_aclk(clk),
    .periph_resetn  (rst_n),
    .eng_start      (eng_start),
    .issue_x        (issue_x),
    .issue_y        (issue_y),
    .eng_done       (eng_done),
    .eng_depth      (eng_depth),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_depth      (out_depth),
    .out_x          (out_x),
    .out_y          (out_y),
    .out_sof        (out_sof),
    .out_eol        (out_eol)
`ifdef ROB_STATS_EN
    ,
    .stat_frames    (stat_frames),
    .stat_starve    (stat_starve)
`endif
  );

  typedef struct {
    int x;
    int y;
    int d;
    bit sof;
    bit eol;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;
  int   lat[NE], tmr[NE], edep[NE], ov_d[NE];
  bit   ov_en[NE];
  int   ix = 0, iy = 0, n_start = 0, n_out = 0, cyc = 0;
  int   out_cyc[8192];
  bit   stale_inject = 1'b0;

  task automatic chk(input bit ok, input string nm, input string det);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", nm, det);
  endtask

  function automatic int fdep(input int x, input int y);
    return (x * 37 + y * 101 + 3) % 1024;
  endfunction

  // Engine pool model: fixed per-engine latency, records expected results at issue
  initial begin
    for (int i = 0; i < NE; i++) begin
      tmr[i] = 0; lat[i] = 5; edep[i] = 0; ov_en[i] = 1'b0; ov_d[i] = 0;
    end
    forever begin
      logic [NE-1:0]    dv;
      logic [NE*DW-1:0] dp;
      @(negedge clk);
      cyc++;
      dv = '0;
      dp = '0;
      if (!rst_n) begin
        for (int i = 0; i < NE; i++) tmr[i] = 0;
        sb.delete();
        ix = 0;
        iy = 0;
      end else begin
        for (int i = 0; i < NE; i++) begin
          if (tmr[i] > 0) begin
            tmr[i]--;
            if (tmr[i] == 0) begin
              dv[i] = 1'b1;
              dp[i*DW +: DW] = DW'(edep[i]);
            end
          end
        end
        if (eng_start != '0) begin
          int   e;
          exp_t t;
          n_start++;
          e = 0;
          for (int i = NE - 1; i >= 0; i--) if (eng_start[i]) e = i;
          chk($onehot(eng_start) && (int'(issue_x) == ix) && (int'(issue_y) == iy) && (tmr[e] == 0),
              "issue", $sformatf("start=%b x=%0d y=%0d, required one-hot idle engine at x=%0d y=%0d",
                                 eng_start, issue_x, issue_y, ix, iy));
          t.x = ix; t.y = iy;
          t.d = ov_en[e] ? ov_d[e] : fdep(ix, iy);
          t.sof = (ix == 0) && (iy == 0);
          t.eol = (ix == XS - 1);
          ov_en[e] = 1'b0;
          edep[e] = t.d;
          tmr[e] = lat[e];
          sb.push_back(t);
          if (ix == XS - 1) begin
            ix = 0;
            iy = (iy == YS - 1) ? 0 : iy + 1;
          end else begin
            ix++;
          end
        end
      end
      if (stale_inject) begin
        dv = '1;
        dp = '1;
        stale_inject = 1'b0;
      end
      eng_done = dv;
      eng_depth = dp;
    end
  end

  // Output monitor: scoreboard compare on accept, stability check while stalled
  initial begin
    bit            hp;
    logic [DW-1:0] pd;
    logic [9:0]    px;
    logic [8:0]    py;
    hp = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        hp = 1'b0;
      end else begin
        if (hp)
          chk((out_valid === 1'b1) && out_depth == pd && out_x == px && out_y == py, "hold",
              $sformatf("valid=%b d=%0d (%0d,%0d), required held d=%0d (%0d,%0d)",
                        out_valid, out_depth, out_x, out_y, pd, px, py));
        hp = out_valid && !out_ready;
        pd = out_depth; px = out_x; py = out_y;
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_out", $sformatf("got d=%0d (%0d,%0d), required nothing pending",
                                                  out_depth, out_x, out_y));
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk(int'(out_x) == e.x && int'(out_y) == e.y && out_depth == DW'(e.d) &&
                out_sof == e.sof && out_eol == e.eol, "out",
                $sformatf("got d=%0d (%0d,%0d) sof=%b eol=%b, required d=%0d (%0d,%0d) sof=%b eol=%b",
                          out_depth, out_x, out_y, out_sof, out_eol, e.d, e.x, e.y, e.sof, e.eol));
          end
          if (n_out < 8192) out_cyc[n_out] = cyc;
          n_out++;
        end
      end
    end
  end

  task automatic chk_reset_vals();
    chk(eng_start == '0, "rst_start", $sformatf("got %b, required 0", eng_start));
    chk(issue_x == 0 && issue_y == 0, "rst_issue", $sformatf("got (%0d,%0d), required (0,0)", issue_x, issue_y));
    chk(out_valid == 1'b0, "rst_valid", $sformatf("got %b, required 0", out_valid));
    chk(out_depth == 0 && out_x == 0 && out_y == 0, "rst_out",
        $sformatf("got d=%0d (%0d,%0d), required 0 (0,0)", out_depth, out_x, out_y));
    chk(out_sof == 1'b1 && out_eol == 1'b0, "rst_flags", $sformatf("got sof=%b eol=%b, required 1 0", out_sof, out_eol));
  endtask

  task automatic assert_rst();
    @(negedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic release_rst(input bit stale);
    @(negedge clk);
    @(posedge clk);
    #1 stale_inject = stale;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int tgt;
    int k;
    tgt = n_out + n;
    k = 0;
    while (n_out < tgt && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(n_out >= tgt, "wait_outs", $sformatf("got %0d outputs, required %0d within %0d cycles", n_out, tgt, budget));
  endtask

  initial begin
    int base, tr, s0, s1;
    // Reset values
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();

    // Fixed latency, always ready: raster order across frame boundaries
    out_ready = 1'b1;
    release_rst(1'b0);
    wait_outs(20, 400);

    // Slow engine 0: later pixels held, then delivered back to back
    assert_rst();
    lat[0] = 20; lat[1] = 2; lat[2] = 2; lat[3] = 2;
    release_rst(1'b0);
    base = n_out;
    tr = cyc;
    wait_outs(4, 200);
    chk(out_cyc[base] - tr >= 20, "slow_first", $sformatf("first accept after %0d cycles, required >= 20", out_cyc[base] - tr));
    for (int k = 1; k < 4; k++)
      chk(out_cyc[base+k] - out_cyc[base+k-1] == 1, "no_bubble",
          $sformatf("gap %0d before output %0d, required 1", out_cyc[base+k] - out_cyc[base+k-1], k));

    // Output stall: issue stops at a full ROB, drains back to back, then resumes
    assert_rst();
    out_ready = 1'b0;
    for (int i = 0; i < NE; i++) lat[i] = 5;
    release_rst(1'b0);
    s0 = n_start;
    repeat (50) @(negedge clk);
    chk(n_start - s0 == RD, "full_starts", $sformatf("got %0d starts, required %0d", n_start - s0, RD));
    out_ready = 1'b1;
    base = n_out;
    s1 = n_start;
    wait_outs(8, 100);
    for (int k = 1; k < 8; k++)
      chk(out_cyc[base+k] - out_cyc[base+k-1] == 1, "drain",
          $sformatf("gap %0d before output %0d, required 1", out_cyc[base+k] - out_cyc[base+k-1], k));
    chk(n_start > s1, "issue_resume", $sformatf("got %0d starts, required more than %0d", n_start, s1));

    // Simultaneous dones from engines 1 and 2 with depths 7 and 200
    assert_rst();
    lat[0] = 10; lat[1] = 6; lat[2] = 5; lat[3] = 10;
    ov_en[1] = 1'b1; ov_d[1] = 7;
    ov_en[2] = 1'b1; ov_d[2] = 200;
    release_rst(1'b0);
    wait_outs(8, 200);

    // Mid-frame reset with busy engines, stale dones just after release
    for (int i = 0; i < NE; i++) lat[i] = 5;
    repeat (13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals();
    release_rst(1'b1);
    wait_outs(4, 100);

`ifdef ROB_STATS_EN
    assert_rst();
    out_ready = 1'b0;
    for (int i = 0; i < NE; i++) lat[i] = 30;
    release_rst(1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    #1 chk(stat_starve == 32'd10, "stat_starve", $sformatf("got %0d, required 10", stat_starve));
    out_ready = 1'b1;
    wait_outs(16, 400);
    out_ready = 1'b0;
    #1 chk(stat_frames == 16'd2, "stat_frames", $sformatf("got %0d, required 2", stat_frames));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
